// File: rtl/memory_arbiter.sv
// Two-requester arbiter (instruction fetch and data) in front of a single-port memory.
// One transaction in flight; data has priority but fetch is forced through after a data streak.
module memory_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_address,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  input  logic        d_write,
  input  logic [2:0]  d_format,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic [2:0]  mem_format,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

  state_t      state_q, state_d;
  logic        owner_data_q, owner_data_d;
  logic [3:0]  streak_q, streak_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_write_q, mem_write_d;
  logic [2:0]  mem_format_q, mem_format_d;
  logic [31:0] rdata_q, rdata_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;

  // Next-state, capture and output-register logic for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    owner_data_d  = owner_data_q;
    streak_d      = streak_q;
    mem_req_d     = 1'b0;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_write_d   = mem_write_q;
    mem_format_d  = mem_format_q;
    rdata_d       = rdata_q;
    if_rvalid_d   = 1'b0;
    d_rvalid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // Data wins unless a waiting fetch has already lost MAX_DATA_STREAK times.
          if (d_req && !(if_req && (streak_q == MAX_STREAK))) begin
            owner_data_d  = 1'b1;
            mem_address_d = d_address;
            mem_wdata_d   = d_wdata;
            mem_write_d   = d_write;
            mem_format_d  = d_format;
            if (!if_req) begin
              streak_d = 4'd0;
            end else if (streak_q >= MAX_STREAK) begin
              streak_d = MAX_STREAK;
            end else begin
              streak_d = streak_q + 4'd1;
            end
          end else begin
            owner_data_d  = 1'b0;
            mem_address_d = if_address;
            mem_wdata_d   = 32'd0;
            mem_write_d   = 1'b0;
            mem_format_d  = 3'b010;
            streak_d      = 4'd0;
          end
          mem_req_d = 1'b1;
          state_d   = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = RESP;
        end else begin
          mem_req_d = 1'b1;
          state_d   = REQ;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          rdata_d     = mem_rdata;
          if_rvalid_d = !owner_data_q;
          d_rvalid_d  = owner_data_q;
          state_d     = DONE;
        end else begin
          state_d = RESP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_data_q  <= 1'b0;
      streak_q      <= 4'd0;
      mem_req_q     <= 1'b0;
      mem_address_q <= 32'd0;
      mem_wdata_q   <= 32'd0;
      mem_write_q   <= 1'b0;
      mem_format_q  <= 3'd0;
      rdata_q       <= 32'd0;
      if_rvalid_q   <= 1'b0;
      d_rvalid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_data_q  <= owner_data_d;
      streak_q      <= streak_d;
      mem_req_q     <= mem_req_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_write_q   <= mem_write_d;
      mem_format_q  <= mem_format_d;
      rdata_q       <= rdata_d;
      if_rvalid_q   <= if_rvalid_d;
      d_rvalid_q    <= d_rvalid_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_write   = mem_write_q;
  assign mem_format  = mem_format_q;
  assign if_rvalid   = if_rvalid_q;
  assign d_rvalid    = d_rvalid_q;
  assign if_rdata    = rdata_q;
  assign d_rdata     = rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a vector table of single transactions plus
// hand-written sequences for starvation, grant stall, reset abort and held requests.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_address;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic        d_write;
  logic [2:0]  d_format;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [2:0]  mem_format;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  memory_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_address(if_address), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_address(d_address), .d_wdata(d_wdata), .d_write(d_write),
    .d_format(d_format), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_format(mem_format), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_write;
    logic [2:0]  d_fmt;
    logic [31:0] rdata;
    logic        exp_data;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_write;
    logic [2:0]  exp_fmt;
  } vec_t;

  vec_t vecs[6];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs;
    if_req = 1'b0; if_address = 32'd0;
    d_req = 1'b0; d_address = 32'd0; d_wdata = 32'd0; d_write = 1'b0; d_format = 3'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // Waits (bounded) for mem_req, grants it, answers, and returns what was granted.
  task automatic serve(input logic [31:0] rd, output logic got_d, output logic [31:0] a,
                       output logic [31:0] wd, output logic w, output logic [2:0] f,
                       output int waited);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("serve_mem_req", {31'd0, mem_req}, 32'd1);
    a = mem_address; wd = mem_wdata; w = mem_write; f = mem_format; waited = n;
    mem_gnt = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    got_d = d_rvalid;
    check("serve_one_rvalid", {31'd0, if_rvalid ^ d_rvalid}, 32'd1);
    check("serve_rdata", if_rdata, rd);
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        gd;
    logic [31:0] ga, gw;
    logic        gwr;
    logic [2:0]  gf;
    int          waited;
    logic [6:0]  exp_order;
    int          dcount;
    int          rises, pulses;
    logic        prev, seen;

    vecs[0] = '{1'b1, 32'h100, 1'b0, 32'h0,    32'h0,        1'b0, 3'b000, 32'h00000013,
                1'b0, 32'h100, 32'h0, 1'b0, 3'b010};
    vecs[1] = '{1'b0, 32'h0,   1'b1, 32'h3000, 32'h55,       1'b0, 3'b100, 32'hCAFEF00D,
                1'b1, 32'h3000, 32'h55, 1'b0, 3'b100};
    vecs[2] = '{1'b1, 32'h140, 1'b1, 32'h2000, 32'hDEADBEEF, 1'b1, 3'b010, 32'h0,
                1'b1, 32'h2000, 32'hDEADBEEF, 1'b1, 3'b010};
    vecs[3] = '{1'b1, 32'h104, 1'b0, 32'h0,    32'h0,        1'b0, 3'b000, 32'h00100093,
                1'b0, 32'h104, 32'h0, 1'b0, 3'b010};
    vecs[4] = '{1'b0, 32'h0,   1'b1, 32'h2001, 32'hAB,       1'b1, 3'b000, 32'h11111111,
                1'b1, 32'h2001, 32'hAB, 1'b1, 3'b000};
    vecs[5] = '{1'b1, 32'h200, 1'b1, 32'h10,   32'h0,        1'b0, 3'b101, 32'hFFFF8000,
                1'b1, 32'h10, 32'h0, 1'b0, 3'b101};

    do_reset();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_write_fmt", {28'd0, mem_write, mem_format}, 32'd0);
    check("rst_rdata", if_rdata, 32'd0);

    // Single transactions at minimum latency: REQ at +1, RESP at +2, DONE at +3, IDLE at +4.
    for (int i = 0; i < 6; i++) begin
      if_req = vecs[i].if_req; if_address = vecs[i].if_addr;
      d_req = vecs[i].d_req; d_address = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      d_write = vecs[i].d_write; d_format = vecs[i].d_fmt; mem_gnt = 1'b1;
      tick();
      check("vec_c1_mem_req", {31'd0, mem_req}, 32'd1);
      check("vec_c1_address", mem_address, vecs[i].exp_addr);
      check("vec_c1_wdata", mem_wdata, vecs[i].exp_wdata);
      check("vec_c1_write", {31'd0, mem_write}, {31'd0, vecs[i].exp_write});
      check("vec_c1_format", {29'd0, mem_format}, {29'd0, vecs[i].exp_fmt});
      tick();
      check("vec_c2_mem_req", {31'd0, mem_req}, 32'd0);
      check("vec_c2_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = vecs[i].rdata;
      tick();
      check("vec_c3_rvalids", {30'd0, if_rvalid, d_rvalid},
            {30'd0, !vecs[i].exp_data, vecs[i].exp_data});
      check("vec_c3_if_rdata", if_rdata, vecs[i].rdata);
      check("vec_c3_d_rdata", d_rdata, vecs[i].rdata);
      if_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b0;
      tick();
      check("vec_c4_idle", {29'd0, mem_req, if_rvalid, d_rvalid}, 32'd0);
    end

    // Simultaneous requests: data store first, fetch at the following arbitration.
    if_req = 1'b1; if_address = 32'h180;
    d_req = 1'b1; d_address = 32'h2000; d_wdata = 32'hDEADBEEF; d_write = 1'b1; d_format = 3'b010;
    serve(32'h0, gd, ga, gw, gwr, gf, waited);
    check("sim_first_is_data", {31'd0, gd}, 32'd1);
    check("sim_data_fields", ga ^ gw, 32'h2000 ^ 32'hDEADBEEF);
    check("sim_data_write_fmt", {28'd0, gwr, gf}, {28'd0, 1'b1, 3'b010});
    check("sim_data_wait", waited, 1);
    d_req = 1'b0;
    serve(32'h13, gd, ga, gw, gwr, gf, waited);
    check("sim_second_is_fetch", {31'd0, gd}, 32'd0);
    check("sim_fetch_addr", ga, 32'h180);
    check("sim_fetch_wdata", gw, 32'd0);
    check("sim_fetch_write_fmt", {28'd0, gwr, gf}, {28'd0, 1'b0, 3'b010});
    check("sim_fetch_wait", waited, 2);
    if_req = 1'b0;

    // Starvation guard: fetch held, six data requests, cap of four.
    do_reset();
    exp_order = 7'b1101111;
    dcount = 6;
    if_req = 1'b1; if_address = 32'h300;
    d_req = 1'b1; d_address = 32'h4000; d_write = 1'b0; d_format = 3'b010;
    for (int k = 0; k < 7; k++) begin
      serve(32'(k), gd, ga, gw, gwr, gf, waited);
      check($sformatf("starve_order_%0d", k), {31'd0, gd}, {31'd0, exp_order[k]});
      if (gd) begin
        dcount--;
        if (dcount == 0) d_req = 1'b0;
      end else begin
        if_req = 1'b0;
      end
    end
    clear_inputs();
    tick();

    // Grant stall: fields frozen, spurious mem_rvalid ignored while waiting.
    d_req = 1'b1; d_address = 32'h5000; d_wdata = 32'h12345678; d_write = 1'b1; d_format = 3'b001;
    mem_gnt = 1'b0;
    tick();
    check("stall_req", {31'd0, mem_req}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hBADBAD00;
      tick();
      check("stall_hold_req", {31'd0, mem_req}, 32'd1);
      check("stall_hold_addr", mem_address, 32'h5000);
      check("stall_hold_wdata", mem_wdata, 32'h12345678);
      check("stall_hold_wr_fmt", {28'd0, mem_write, mem_format}, {28'd0, 1'b1, 3'b001});
      check("stall_no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    tick();
    check("stall_resp_req_low", {31'd0, mem_req}, 32'd0);
    tick();
    check("stall_resp_wait", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick();
    check("stall_done_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd1);
    check("stall_done_rdata", d_rdata, 32'hA5A5A5A5);
    clear_inputs();
    tick();

    // Reset while in RESP, then a late response must not surface.
    if_req = 1'b1; if_address = 32'h700; mem_gnt = 1'b1;
    tick();
    tick();
    check("abort_in_resp", {31'd0, mem_req}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0; if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000BAD;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("abort_no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      check("abort_mem_req", {31'd0, mem_req}, 32'd0);
      check("abort_rdata", if_rdata, 32'd0);
    end
    clear_inputs();
    tick();

    // Request held through DONE, dropped the cycle after: exactly one grant.
    d_req = 1'b1; d_address = 32'h6000; d_write = 1'b0; d_format = 3'b010;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    rises = 0; pulses = 0; prev = 1'b0; seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (mem_req && !prev) rises++;
      prev = mem_req;
      if (d_rvalid) begin
        pulses++;
        seen = 1'b1;
        check("held_rdata", d_rdata, 32'h77);
      end else if (seen) begin
        d_req = 1'b0;
      end
    end
    check("held_one_mem_req", rises, 1);
    check("held_one_rvalid", pulses, 1);
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter MAX_DATA_STREAK, default 4, SHALL set the maximum number of consecutive contended data grants before a pending fetch is forced through (legal range 1..15).
REQ-002 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch request, held with if_address until if_rvalid.
REQ-006 if_address  in  32  fetch address.
REQ-007 if_rvalid  out  1  one-cycle pulse marking fetch completion.
REQ-008 if_rdata  out  32  fetched word, valid while if_rvalid=1.
REQ-009 d_req  in  1  data request, held with all d_* fields until d_rvalid.
REQ-010 d_address / d_wdata  in  32 / 32  data address, store data.
REQ-011 d_write  in  1  1=store, 0=load.
REQ-012 d_format  in  3  funct3 access format, passed through unchanged.
REQ-013 d_rvalid  out  1  one-cycle pulse marking load or store completion.
REQ-014 d_rdata  out  32  load data, valid while d_rvalid=1.
REQ-015 mem_req  out  1  request to the single-port memory.
REQ-016 mem_address / mem_wdata  out  32 / 32  captured address and store data.
REQ-017 mem_write / mem_format  out  1 / 3  captured write flag and format.
REQ-018 mem_gnt  in  1  memory accepts the request in the same cycle mem_req=1.
REQ-019 mem_rvalid / mem_rdata  in  1 / 32  response, one per granted request, loads and stores alike.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, RESP and DONE, with exactly one transaction outstanding at a time.
REQ-021 IDLE: if if_req or d_req is set, the block SHALL select an owner, capture the owner's fields into registers and go to REQ; otherwise it SHALL stay in IDLE.
REQ-022 Arbitration SHALL favour data, except that fetch wins when if_req=1 and the streak counter equals MAX_DATA_STREAK.
REQ-023 Streak counter (4-bit) update: a data grant with if_req=1 SHALL increment it, saturating at MAX_DATA_STREAK; a data grant with if_req=0 SHALL clear it; a fetch grant SHALL clear it.
REQ-024 A fetch capture SHALL load mem_write=0, mem_format=3'b010 and mem_wdata=0.
REQ-025 REQ: mem_req=1 and the captured fields SHALL be held stable; on mem_gnt=1 the FSM SHALL go to RESP, otherwise it SHALL stay in REQ.
REQ-026 RESP: mem_req=0; on mem_rvalid=1 the block SHALL register mem_rdata and go to DONE.
REQ-027 DONE: the owner's rvalid SHALL be 1 for exactly this cycle with the registered rdata; the other rvalid SHALL be 0; the next state SHALL be IDLE.
REQ-028 In DONE, requests SHALL be ignored, so a held req is never re-granted; the requester may present a new request from the following cycle.
REQ-029 Minimum latency SHALL be: req sampled at cycle 0, mem_req at 1, gnt at 1, rvalid at 2, owner rvalid at 3, next arbitration at 4.
REQ-030 mem_rvalid outside RESP SHALL be ignored (stale or spurious); mem_gnt outside REQ SHALL be ignored.
REQ-031 if_rdata and d_rdata SHALL both be driven from the same rdata register; only the rvalid pulses differ.

Reset
REQ-032 On reset: state=IDLE, mem_req=0, if_rvalid=0, d_rvalid=0, streak=0, and the rdata register and all mem_* output registers=0.
REQ-033 Reset mid-transaction (REQ/RESP/DONE) SHALL abort it with no rvalid pulse; a later mem_rvalid for the aborted transaction SHALL be ignored because the block is in IDLE.

Verification
REQ-034 Fetch only: if_req=1, if_address=0x100, mem_gnt tied 1, mem_rvalid one cycle after grant with rdata=0x00000013 -> mem_req at cycle 1 with mem_write=0, format=010; if_rvalid=1 with if_rdata=0x13 at cycle 3.
REQ-035 Simultaneous requests: if_req=d_req=1, store 0xDEADBEEF to 0x2000 -> data granted first (mem_write=1, mem_wdata=0xDEADBEEF, d_format passed through); fetch granted in the next IDLE.
REQ-036 Starvation: if_req held, 6 back-to-back data requests, MAX_DATA_STREAK=4 -> grant order D,D,D,D,F,D,D.
REQ-037 Grant wait: mem_gnt=0 for 5 cycles -> mem_req and all mem_* stay constant; rvalid only after gnt plus response.
REQ-038 Reset in RESP, then mem_rvalid=1 -> no if_rvalid or d_rvalid, state IDLE, mem_req=0.
REQ-039 Held req through DONE -> exactly one mem_req per transaction, with no duplicate grant.
